ram_port_arbiter: RTL and testbench

Shares the single-port 8K×32 data/program RAM between up to four requesters: core instruction fetch, core load/store, the UART boot loader and the GPIO/debug port. The block sits between those requesters and the RAM macro. It issues at most one RAM access per clock, using round-robin arbitration with optional bounded burst locking, and returns read data with per-requester valid strobes.

---
 rtl/ram_port_arbiter_if.sv | 31 +++
 rtl/ram_port_arbiter.sv | 102 ++++++++++
 tb/tb_ram_port_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-macro signal bundle for ram_port_arbiter.
// slave is the arbiter side; master is the requester/RAM side.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic [ADDR_W-1:0]       ram_addr;
  logic                    ram_we;
  logic [DATA_W-1:0]       ram_wdata;
  logic [DATA_W-1:0]       ram_rdata;
  logic                    owner_busy;

  modport slave (
    input  req, lock, we, addr, wdata, ram_rdata,
    output gnt, rvalid, rdata, ram_addr, ram_we, ram_wdata, owner_busy
  );

  modport master (
    output req, lock, we, addr, wdata, ram_rdata,
    input  gnt, rvalid, rdata, ram_addr, ram_we, ram_wdata, owner_busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin single-port RAM arbiter with bounded burst lock; grant is same-cycle,
// rvalid one cycle after a read grant; losers simply hold req until granted.
module ram_port_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8
) (
  input logic              clk,
  input logic              rst_n,
  ram_port_arbiter_if.slave bus
);
  localparam int         PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [8:0] MAX_B = 9'(MAX_BURST);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic [N_REQ-1:0] rvalid_q;

  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             hold_owner;
  logic [N_REQ-1:0] gnt;
  logic [8:0]       burst_inc;
  int               idx;

  // A locked owner that drops req releases in the same cycle and the normal search runs.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    idx        = 0;
    hold_owner = rst_n && (state_q == ST_LOCKED) && bus.req[owner_q];
    if (hold_owner) begin
      gnt_any = 1'b1;
      gnt_idx = owner_q;
    end else if (rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = (int'(rr_ptr_q) + i) % N_REQ;
        if (!gnt_any && bus.req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end
    gnt = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    burst_inc   = {1'b0, burst_cnt_q} + 9'd1;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
    if (hold_owner) begin
      if (!bus.lock[owner_q] || burst_inc >= MAX_B) begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = burst_inc[7:0];
      end
    end else begin
      state_d     = ST_IDLE;
      burst_cnt_d = '0;
      if (gnt_any && bus.lock[gnt_idx] && (MAX_BURST > 1)) begin
        state_d     = ST_LOCKED;
        owner_d     = gnt_idx;
        burst_cnt_d = 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= gnt & ~bus.we;
    end
  end

  assign bus.gnt        = gnt;
  assign bus.ram_addr   = gnt_any ? bus.addr[gnt_idx*ADDR_W +: ADDR_W]  : '0;
  assign bus.ram_wdata  = gnt_any ? bus.wdata[gnt_idx*DATA_W +: DATA_W] : '0;
  assign bus.ram_we     = gnt_any & bus.we[gnt_idx];
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = bus.ram_rdata;
  assign bus.owner_busy = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a write-first 8Kx32 RAM model.
module tb_ram_port_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int NR = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [3:0]    rr_exp [0:7];

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(NR)) bus ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(NR), .MAX_BURST(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata     <= bus.ram_wdata;
    end else begin
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req   = '0;
    bus.lock  = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    bus.ram_rdata = '0;
    mem[13'h0A5] = 32'h1234_5678;
    mem[13'h1FFF] = 32'h0;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001; rr_exp[5] = 4'b0010; rr_exp[6] = 4'b0100; rr_exp[7] = 4'b1000;

    // Reset state, with requests present to show gnt is forced low
    bus.req = 4'b1111;
    #2;
    chk("rst_gnt", 64'(bus.gnt), 64'h0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
    chk("rst_busy", 64'(bus.owner_busy), 64'h0);
    chk("rst_ram_we", 64'(bus.ram_we), 64'h0);
    chk("rst_ram_addr", 64'(bus.ram_addr), 64'h0);
    do_reset();

    // Single read by requester 1
    bus.req = 4'b0010;
    bus.addr[1*AW +: AW] = 13'h0A5;
    #1;
    chk("rd_gnt", 64'(bus.gnt), 64'h2);
    chk("rd_ram_addr", 64'(bus.ram_addr), 64'h0A5);
    chk("rd_ram_we", 64'(bus.ram_we), 64'h0);
    tick();
    idle_inputs();
    #1;
    chk("rd_rvalid", 64'(bus.rvalid), 64'h2);
    chk("rd_rdata", 64'(bus.rdata), 64'h1234_5678);
    chk("rd_idle_gnt", 64'(bus.gnt), 64'h0);

    // Burst cap: rr_ptr now 2, so requester 2 wins first and locks
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.req  = 4'b0101;
      bus.lock = 4'b0100;
      #1;
      chk($sformatf("burst_gnt_%0d", c), 64'(bus.gnt), 64'h4);
      chk($sformatf("burst_busy_%0d", c), 64'(bus.owner_busy), (c >= 2) ? 64'h1 : 64'h0);
    end
    tick();
    #1;
    chk("burst_end_gnt", 64'(bus.gnt), 64'h1);
    chk("burst_end_busy", 64'(bus.owner_busy), 64'h0);
    tick();
    #1;
    chk("relock_gnt", 64'(bus.gnt), 64'h4);

    // Owner drop while locked: requester 0 wins in the same cycle
    tick();
    bus.req  = 4'b0001;
    bus.lock = 4'b0000;
    #1;
    chk("drop_busy_before", 64'(bus.owner_busy), 64'h1);
    chk("drop_gnt", 64'(bus.gnt), 64'h1);
    tick();
    idle_inputs();
    #1;
    chk("drop_busy_after", 64'(bus.owner_busy), 64'h0);
    chk("drop_idle_gnt", 64'(bus.gnt), 64'h0);

    // Round robin from a fresh reset
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.req = 4'b1111;
      #1;
      chk($sformatf("rr_gnt_%0d", c), 64'(bus.gnt), 64'(rr_exp[c]));
      tick();
      chk($sformatf("rr_rvalid_%0d", c), 64'(bus.rvalid), 64'(rr_exp[c]));
    end
    idle_inputs();
    #1;
    chk("rr_tail_gnt", 64'(bus.gnt), 64'h0);

    // Write by requester 3 then read-back by requester 0
    tick();
    bus.req = 4'b1000;
    bus.we  = 4'b1000;
    bus.addr[3*AW +: AW]  = 13'h1FFF;
    bus.wdata[3*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    chk("wr_gnt", 64'(bus.gnt), 64'h8);
    chk("wr_ram_we", 64'(bus.ram_we), 64'h1);
    chk("wr_ram_addr", 64'(bus.ram_addr), 64'h1FFF);
    chk("wr_ram_wdata", 64'(bus.ram_wdata), 64'hDEAD_BEEF);
    tick();
    idle_inputs();
    bus.req = 4'b0001;
    bus.addr[0*AW +: AW] = 13'h1FFF;
    #1;
    chk("rb_gnt", 64'(bus.gnt), 64'h1);
    chk("rb_ram_we", 64'(bus.ram_we), 64'h0);
    chk("wr_no_rvalid", 64'(bus.rvalid), 64'h0);
    tick();
    idle_inputs();
    #1;
    chk("rb_rvalid", 64'(bus.rvalid), 64'h1);
    chk("rb_rdata", 64'(bus.rdata), 64'hDEAD_BEEF);

    // Reset mid-read: rr_ptr is 1 here, grant to 1 then reset at the next edge
    tick();
    bus.req = 4'b0010;
    #1;
    chk("mr_gnt", 64'(bus.gnt), 64'h2);
    #6;
    rst_n = 1'b0;
    tick();
    chk("mr_rvalid_in_rst", 64'(bus.rvalid), 64'h0);
    chk("mr_gnt_in_rst", 64'(bus.gnt), 64'h0);
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    chk("mr_rvalid_after", 64'(bus.rvalid), 64'h0);
    bus.req = 4'b0110;
    #1;
    chk("mr_prio_from_0", 64'(bus.gnt), 64'h2);
    tick();
    idle_inputs();
    #1;
    chk("mr_rvalid_new", 64'(bus.rvalid), 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
